// File: rtl/reservoir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reservoir_pkg
// Description : Shared reservoir constants, sensor-vector type and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package reservoir_pkg;

    localparam int c_level_w      = 12;
    localparam int c_init_level   = 3584;
    localparam int c_s1_level     = 1024;
    localparam int c_s2_level     = 2048;
    localparam int c_s3_level     = 3072;
    localparam int c_hyst         = 16;
    localparam int c_tick_div     = 4;
    localparam int c_fr_rate      = 2;
    localparam int c_afr_rate     = 4;
    localparam int c_demand_rate  = 3;
    localparam int c_debounce     = 4;
    localparam int c_fault_ticks  = 8;

    typedef struct packed {
        logic s3;
        logic s2;
        logic s1;
    } sensor_vec_t;

    function automatic logic sensor_init(input int level, input int threshold);
        return (level >= threshold) ? 1'b1 : 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reservoir_level_sensor_if.sv
`default_nettype none
// ============================================================================
// Module      : reservoir_level_sensor_if
// Description : Valve-command / level-sensor link between controller and plant.
// Revision    : 1.0 - initial release
// ============================================================================
interface reservoir_level_sensor_if #(
    parameter int LEVEL_W = reservoir_pkg::c_level_w
);
    logic               FR1;
    logic               FR2;
    logic               FR3;
    logic               AFR;
    logic               demand_en;
    logic               level_load;
    logic [LEVEL_W-1:0] level_load_val;
    logic               S1;
    logic               S2;
    logic               S3;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic               underflow;
    logic               ctrl_fault;

    modport master (
        output FR1, FR2, FR3, AFR, demand_en, level_load, level_load_val,
        input  S1, S2, S3, level, overflow, underflow, ctrl_fault
    );

    modport slave (
        input  FR1, FR2, FR3, AFR, demand_en, level_load, level_load_val,
        output S1, S2, S3, level, overflow, underflow, ctrl_fault
    );
endinterface
`default_nettype wire

// File: rtl/level_debounce.sv
`default_nettype none
// ============================================================================
// Module      : level_debounce
// Description : Toggles its output after DEBOUNCE consecutive mismatching edges.
// Revision    : 1.0 - initial release
// ============================================================================
module level_debounce #(
    parameter int   DEBOUNCE  = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic sense
);
    localparam int c_cnt_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sense;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_sense <= RESET_VAL;
        end else if (raw == r_sense) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
            r_cnt   <= '0;
            r_sense <= ~r_sense;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign sense = r_sense;
endmodule
`default_nettype wire

// File: rtl/reservoir_level_sensor.sv
`default_nettype none
// ============================================================================
// Module      : reservoir_level_sensor
// Description : Reservoir plant model: saturating level integrator with
//               hysteretic, debounced S1/S2/S3 sensors. Optional controller
//               consistency checker enabled by RESERVOIR_CTRL_FAULT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reservoir_level_sensor
    import reservoir_pkg::*;
#(
    parameter int LEVEL_W     = c_level_w,
    parameter int INIT_LEVEL  = c_init_level,
    parameter int S1_LEVEL    = c_s1_level,
    parameter int S2_LEVEL    = c_s2_level,
    parameter int S3_LEVEL    = c_s3_level,
    parameter int HYST        = c_hyst,
    parameter int TICK_DIV    = c_tick_div,
    parameter int FR_RATE     = c_fr_rate,
    parameter int AFR_RATE    = c_afr_rate,
    parameter int DEMAND_RATE = c_demand_rate,
    parameter int DEBOUNCE    = c_debounce
`ifdef RESERVOIR_CTRL_FAULT_CHECK_EN
    ,
    parameter int FAULT_TICKS = c_fault_ticks
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    reservoir_level_sensor_if.slave  bus
);
    localparam int c_sum_w   = LEVEL_W + 2;
    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [c_presc_w-1:0] r_presc;
    logic [LEVEL_W-1:0]   r_level;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 w_tick;
    logic [c_sum_w-1:0]   w_inflow;
    logic [c_sum_w-1:0]   w_outflow;
    logic [c_sum_w-1:0]   w_sum;
    logic [LEVEL_W-1:0]   w_level_next;
    logic                 w_ovf_hit;
    logic                 w_unf_hit;
    logic [2:0]           w_sense;
    sensor_vec_t          w_sensors;

    assign w_tick = (r_presc == c_presc_w'(TICK_DIV - 1));

    always_comb begin
        w_inflow  = '0;
        w_outflow = '0;
        if (bus.FR1) w_inflow = w_inflow + c_sum_w'(FR_RATE);
        if (bus.FR2) w_inflow = w_inflow + c_sum_w'(FR_RATE);
        if (bus.FR3) w_inflow = w_inflow + c_sum_w'(FR_RATE);
        if (bus.AFR) w_inflow = w_inflow + c_sum_w'(AFR_RATE);
        if (bus.demand_en) w_outflow = c_sum_w'(DEMAND_RATE);
    end

    // Two's-complement sum: MSB flags a negative result, the next bit a carry past full scale.
    assign w_sum = {2'b00, r_level} + w_inflow - w_outflow;

    always_comb begin
        w_level_next = w_sum[LEVEL_W-1:0];
        w_ovf_hit    = 1'b0;
        w_unf_hit    = 1'b0;
        if (w_sum[c_sum_w-1]) begin
            w_level_next = '0;
            w_unf_hit    = 1'b1;
        end else if (w_sum[LEVEL_W]) begin
            w_level_next = '1;
            w_ovf_hit    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level     <= LEVEL_W'(INIT_LEVEL);
            r_presc     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.level_load) begin
            r_level     <= bus.level_load_val;
            r_presc     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_presc_w'(1);
            if (w_tick) begin
                r_level <= w_level_next;
                if (w_ovf_hit) r_overflow  <= 1'b1;
                if (w_unf_hit) r_underflow <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_sensor
        localparam int   c_thr  = (k == 0) ? S1_LEVEL : (k == 1) ? S2_LEVEL : S3_LEVEL;
        localparam logic c_init = sensor_init(INIT_LEVEL, c_thr);

        logic r_raw;
        logic w_raw;

        // Comparator output feeds the debouncer directly so the first crossing clock counts.
        always_comb begin
            w_raw = r_raw;
            if ({1'b0, r_level} >= (LEVEL_W + 1)'(c_thr + HYST))
                w_raw = 1'b1;
            else if ({1'b0, r_level} < (LEVEL_W + 1)'(c_thr - HYST))
                w_raw = 1'b0;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_raw <= c_init;
            else          r_raw <= w_raw;
        end

        level_debounce #(
            .DEBOUNCE  (DEBOUNCE),
            .RESET_VAL (c_init)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (w_raw),
            .sense   (w_sense[k])
        );
    end

    assign w_sensors     = w_sense;
    assign bus.S1        = w_sensors.s1;
    assign bus.S2        = w_sensors.s2;
    assign bus.S3        = w_sensors.s3;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

`ifdef RESERVOIR_CTRL_FAULT_CHECK_EN
    localparam int c_fault_w = $clog2(FAULT_TICKS + 1);

    logic [c_fault_w-1:0] r_fault_cnt;
    logic                 r_ctrl_fault;
    logic                 w_inconsistent;

    // A valve left open above the level it is meant to fill up to.
    assign w_inconsistent = (bus.FR1 & w_sensors.s3) | (bus.FR2 & w_sensors.s2) |
                            (bus.AFR & w_sensors.s1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_cnt  <= '0;
            r_ctrl_fault <= 1'b0;
        end else if (bus.level_load) begin
            r_fault_cnt  <= '0;
            r_ctrl_fault <= 1'b0;
        end else if (w_tick) begin
            if (w_inconsistent) begin
                if (r_fault_cnt != c_fault_w'(FAULT_TICKS))
                    r_fault_cnt <= r_fault_cnt + c_fault_w'(1);
                if (r_fault_cnt >= c_fault_w'(FAULT_TICKS - 1))
                    r_ctrl_fault <= 1'b1;
            end else begin
                r_fault_cnt <= '0;
            end
        end
    end

    assign bus.ctrl_fault = r_ctrl_fault;
`else
    assign bus.ctrl_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reservoir_level_sensor.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservoir_level_sensor
// Description : Directed bench with a cycle model of the reservoir plant;
//               fault expectations follow RESERVOIR_CTRL_FAULT_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservoir_level_sensor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    reservoir_level_sensor_if bus ();

    reservoir_level_sensor dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plant model: level in plain integers, clock phase counted since the last load.
    int THR [3] = '{1024, 2048, 3072};
    int m_level, m_ph, m_fcnt;
    bit m_ovf, m_unf, m_fault;
    bit m_raw [3];
    bit m_s [3];
    int m_db [3];

    always @(posedge clk or negedge reset_n) begin : model
        bit incons;
        int sum;
        if (!reset_n) begin
            m_level = 3584; m_ph = 0; m_fcnt = 0;
            m_ovf = 0; m_unf = 0; m_fault = 0;
            for (int k = 0; k < 3; k++) begin
                m_raw[k] = (3584 >= THR[k]);
                m_s[k]   = m_raw[k];
                m_db[k]  = 0;
            end
        end else begin
            incons = (bus.FR1 && m_s[2]) || (bus.FR2 && m_s[1]) || (bus.AFR && m_s[0]);
            for (int k = 0; k < 3; k++) begin
                if (m_level >= THR[k] + 16)      m_raw[k] = 1;
                else if (m_level < THR[k] - 16)  m_raw[k] = 0;
                if (m_raw[k] != m_s[k]) begin
                    m_db[k]++;
                    if (m_db[k] == 4) begin
                        m_s[k] = !m_s[k];
                        m_db[k] = 0;
                    end
                end else begin
                    m_db[k] = 0;
                end
            end
            if (bus.level_load) begin
                m_level = int'(bus.level_load_val);
                m_ph = 0; m_ovf = 0; m_unf = 0; m_fcnt = 0; m_fault = 0;
            end else begin
                if (m_ph == 3) begin
                    sum = m_level + 2 * (int'(bus.FR1) + int'(bus.FR2) + int'(bus.FR3))
                          + 4 * int'(bus.AFR) - (bus.demand_en ? 3 : 0);
                    if (sum > 4095) begin
                        m_level = 4095; m_ovf = 1;
                    end else if (sum < 0) begin
                        m_level = 0; m_unf = 1;
                    end else begin
                        m_level = sum;
                    end
`ifdef RESERVOIR_CTRL_FAULT_CHECK_EN
                    if (incons) begin
                        if (m_fcnt < 8) m_fcnt++;
                        if (m_fcnt == 8) m_fault = 1;
                    end else begin
                        m_fcnt = 0;
                    end
`endif
                end
                m_ph = (m_ph + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin : compare
        check("cmp_level", bus.level, m_level);
        check("cmp_s1", bus.S1, m_s[0]);
        check("cmp_s2", bus.S2, m_s[1]);
        check("cmp_s3", bus.S3, m_s[2]);
        check("cmp_overflow", bus.overflow, m_ovf);
        check("cmp_underflow", bus.underflow, m_unf);
        check("cmp_ctrl_fault", bus.ctrl_fault, m_fault);
    end

    // Returns just after the negedge that follows the load edge.
    task automatic load(input int v);
        @(negedge clk); #1;
        bus.level_load = 1'b1;
        bus.level_load_val = 12'(v);
        @(negedge clk); #1;
        bus.level_load = 1'b0;
    endtask

    task automatic set_valves(input bit v);
        bus.FR1 = v; bus.FR2 = v; bus.FR3 = v; bus.AFR = v;
    endtask

    initial begin : stim
        bit seen;
        set_valves(0);
        bus.demand_en = 0; bus.level_load = 0; bus.level_load_val = '0;
        repeat (2) @(negedge clk);
        check("rst_level", bus.level, 3584);
        check("rst_sensors", {bus.S3, bus.S2, bus.S1}, 3'b111);
        check("rst_flags", {bus.overflow, bus.underflow, bus.ctrl_fault}, 3'b000);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_level", bus.level, 3584);

        // Demand draw until S3 drops
        load(3068);
        check("load_level", bus.level, 3068);
        bus.demand_en = 1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.level < 12'd3056) seen = 1;
        end
        check("drop_seen", seen, 1);
        check("drop_level", bus.level, 3053);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("s3_fall", bus.S3, (i == 4) ? 0 : 1);
        end
        #1 bus.demand_en = 0;

        // Overflow
        load(4090);
        set_valves(1);
        repeat (3) @(negedge clk);
        check("ovf_pre_level", bus.level, 4090);
        check("ovf_pre_flag", bus.overflow, 0);
        @(negedge clk);
        check("ovf_level", bus.level, 4095);
        check("ovf_flag", bus.overflow, 1);
        #1 set_valves(0);
        load(100);
        check("ovf_clear", bus.overflow, 0);

        // Underflow
        load(5);
        bus.demand_en = 1;
        repeat (4) @(negedge clk);
        check("unf_level1", bus.level, 2);
        check("unf_flag1", bus.underflow, 0);
        repeat (4) @(negedge clk);
        check("unf_level2", bus.level, 0);
        check("unf_flag2", bus.underflow, 1);
        #1 bus.demand_en = 0;

        // Hysteresis on S3
        load(3584);
        repeat (8) @(negedge clk);
        check("hyst_s3_up", bus.S3, 1);
        load(3060); repeat (6) @(negedge clk);
        load(3080); repeat (6) @(negedge clk);
        load(3060); repeat (6) @(negedge clk);
        check("hyst_s3_hold1", bus.S3, 1);
        load(3050);
        repeat (3) @(negedge clk);
        check("hyst_s3_pre", bus.S3, 1);
        @(negedge clk);
        check("hyst_s3_fall", bus.S3, 0);
        load(3080);
        repeat (8) @(negedge clk);
        check("hyst_s3_hold0", bus.S3, 0);

        // Controller fault: FR1 held open while S3 is high
        load(3584);
        repeat (8) @(negedge clk);
        load(3584);
        bus.FR1 = 1;
        repeat (31) @(negedge clk);
        check("fault_pre", bus.ctrl_fault, 0);
        @(negedge clk);
`ifdef RESERVOIR_CTRL_FAULT_CHECK_EN
        check("fault_set", bus.ctrl_fault, 1);
`else
        check("fault_off", bus.ctrl_fault, 0);
`endif
        check("fault_level", bus.level, 3600);
        #1 bus.FR1 = 0;

        // Reset in the middle of a debounce
        load(3050);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_level", bus.level, 3584);
        check("mid_rst_s3", bus.S3, 1);
        #1 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_s3", bus.S3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
